// File: rtl/spi_manager_sequencer_if.sv
// Byte-stream handshake, mode/timing configuration and SPI bus signals of the SPI manager sequencer.
// The master modport is the sequencer's side. The slave modport is the client/subordinate side.
interface spi_manager_sequencer_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       cfg_cpol;
    logic       cfg_cpha;
    logic [7:0] cfg_half_period;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       cs;
    logic       miso;

    modport master (
        input  tx_valid, tx_data, tx_last, cfg_cpol, cfg_cpha, cfg_half_period, miso,
        output tx_ready, rx_valid, rx_data, busy, sclk, mosi, cs
    );

    modport slave (
        output tx_valid, tx_data, tx_last, cfg_cpol, cfg_cpha, cfg_half_period, miso,
        input  tx_ready, rx_valid, rx_data, busy, sclk, mosi, cs
    );
endinterface

// File: rtl/spi_manager_sequencer.sv
// SPI manager: one byte per handshake, all four SPI modes, programmable SCLK half-period,
// and CS held low across bytes until a byte flagged tx_last completes.
//
// state   | meaning
// IDLE    | cs high, sclk follows live cpol, ready for a byte
// SETUP   | cs low, first mosi bit presented for one half-period
// SHIFT   | 16 sclk edges, drive/sample per cpha
// WAIT    | between bytes of a frame, cs stays low, ready for a byte
// HOLD    | cs still low for one half-period after the last byte
// RELEASE | cs high for CS_HOLD_HALF_PERIODS half-periods before IDLE
module spi_manager_sequencer #(
    parameter int unsigned CS_HOLD_HALF_PERIODS = 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    spi_manager_sequencer_if.master        bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_WAIT,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(CS_HOLD_HALF_PERIODS - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [4:0]  edge_q;
    logic [15:0] hold_q;
    logic [7:0]  tx_q;
    logic        last_q;
    logic        cpol_q;
    logic        cpha_q;
    logic [7:0]  half_q;
    logic [7:0]  rx_sr_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        sclk_q;
    logic        mosi_q;
    logic        cs_q;
    logic        tx_ready_q;
    logic        busy_q;

    logic        accept;
    logic        cnt_tc;
    logic [4:0]  edge_d;
    logic [2:0]  bit_idx;
    logic        drive_now;
    logic        sample_now;
    logic [7:0]  rx_sr_d;

    assign accept  = bus.tx_valid && tx_ready_q;
    assign cnt_tc  = (cnt_q == half_q);
    assign edge_d  = edge_q + 5'd1;
    // Edge 2k (cpha=0) and edge 2k+1 (cpha=1) both present bit 7-k, so one index serves both modes.
    assign bit_idx = 3'd7 - edge_d[3:1];
    assign drive_now  = cpha_q ? edge_d[0] : (!edge_d[0] && (edge_d <= 5'd14));
    assign sample_now = cpha_q ? !edge_d[0] : edge_d[0];
    assign rx_sr_d    = sample_now ? {rx_sr_q[6:0], bus.miso} : rx_sr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            hold_q     <= '0;
            tx_q       <= '0;
            last_q     <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            half_q     <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_WAIT: begin
                    sclk_q <= (state_q == ST_IDLE) ? bus.cfg_cpol : cpol_q;
                    if (accept) begin
                        tx_q       <= bus.tx_data;
                        last_q     <= bus.tx_last;
                        cpol_q     <= bus.cfg_cpol;
                        cpha_q     <= bus.cfg_cpha;
                        half_q     <= bus.cfg_half_period;
                        sclk_q     <= bus.cfg_cpol;
                        mosi_q     <= bus.tx_data[7];
                        cs_q       <= 1'b0;
                        cnt_q      <= '0;
                        edge_q     <= '0;
                        rx_sr_q    <= '0;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_tc) begin
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_tc) begin
                        cnt_q   <= '0;
                        sclk_q  <= ~sclk_q;
                        edge_q  <= edge_d;
                        rx_sr_q <= rx_sr_d;
                        if (drive_now) begin
                            mosi_q <= tx_q[bit_idx];
                        end
                        if (edge_d == 5'd16) begin
                            edge_q     <= '0;
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_sr_d;
                            if (last_q) begin
                                state_q <= ST_HOLD;
                            end else begin
                                tx_ready_q <= 1'b1;
                                state_q    <= ST_WAIT;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_tc) begin
                        cnt_q   <= '0;
                        hold_q  <= '0;
                        cs_q    <= 1'b1;
                        state_q <= ST_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    // A zero hold count still guarantees one clock of cs high.
                    if ((CS_HOLD_HALF_PERIODS == 0) || (cnt_tc && (hold_q == HOLD_LAST))) begin
                        cnt_q      <= '0;
                        hold_q     <= '0;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (cnt_tc) begin
                        cnt_q  <= '0;
                        hold_q <= hold_q + 16'd1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    cs_q       <= 1'b1;
                    tx_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.busy     = busy_q;
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.cs       = cs_q;

endmodule

// File: tb/tb_spi_manager_sequencer.sv
// Directed bench for spi_manager_sequencer: SPI modes, frame CS behaviour, config latching,
// mid-byte reset, long WAIT and the slowest half-period.
module tb_spi_manager_sequencer;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic loop_en = 1'b1;
    logic miso_fix = 1'b0;

    spi_manager_sequencer_if bus ();

    spi_manager_sequencer #(.CS_HOLD_HALF_PERIODS(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.miso = loop_en ? bus.mosi : miso_fix;

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rx_cyc = 0;
    int rx_cnt = 0;
    logic [7:0] rx_byte = '0;
    int sclk_edges = 0;
    int rises = 0;
    int edge_cyc = 0;
    int last_gap = 0;
    int cs_rises = 0;
    int cs_rise_cyc = 0;
    logic [7:0] mosi_cap = '0;
    logic sclk_prev = 1'b0;
    logic cs_prev = 1'b1;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.sclk !== sclk_prev) begin
            sclk_edges = sclk_edges + 1;
            last_gap   = cyc - edge_cyc;
            edge_cyc   = cyc;
            if (bus.sclk) begin
                rises    = rises + 1;
                mosi_cap = {mosi_cap[6:0], bus.mosi};
            end
        end
        sclk_prev = bus.sclk;
        if (bus.cs && !cs_prev) begin
            cs_rises    = cs_rises + 1;
            cs_rise_cyc = cyc;
        end
        cs_prev = bus.cs;
        if (bus.rx_valid) begin
            rx_cnt  = rx_cnt + 1;
            rx_cyc  = cyc;
            rx_byte = bus.rx_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic clr();
        sclk_edges = 0;
        rises      = 0;
        cs_rises   = 0;
        mosi_cap   = '0;
    endtask

    task automatic set_cfg(input logic cpol, input logic cpha, input logic [7:0] half);
        bus.cfg_cpol        = cpol;
        bus.cfg_cpha        = cpha;
        bus.cfg_half_period = half;
    endtask

    task automatic send(input logic [7:0] data, input logic last);
        bit done = 0;
        @(negedge clock);
        #1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = data;
        bus.tx_last  = last;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (bus.tx_ready) begin
                acc_cyc = cyc + 1;
                done    = 1;
            end
            @(negedge clock);
            #1;
        end
        bus.tx_valid = 1'b0;
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_rx(input int target);
        bit done = 0;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clock);
            #1;
            if (rx_cnt >= target) done = 1;
        end
        if (!done) chk("rx_timeout", rx_cnt, target);
    endtask

    initial begin
        int n_rx;
        int ready_seen;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.tx_last  = 1'b0;
        set_cfg(1'b0, 1'b0, 8'd0);

        ticks(3);
        chk("rst_cs", bus.cs, 1);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_mosi", bus.mosi, 0);
        chk("rst_ready", bus.tx_ready, 1);
        chk("rst_rxv", bus.rx_valid, 0);
        chk("rst_rxd", bus.rx_data, 8'h00);
        chk("rst_busy", bus.busy, 0);
        reset_n = 1'b1;
        ticks(3);

        // Mode 0, fastest clock, loopback, single-byte frame.
        clr();
        send(8'hA5, 1'b1);
        chk("m0_busy", bus.busy, 1);
        chk("m0_ready_busy", bus.tx_ready, 0);
        wait_rx(1);
        chk("m0_lat", rx_cyc - acc_cyc, 17);
        chk("m0_rx", rx_byte, 8'hA5);
        chk("m0_mosi", mosi_cap, 8'hA5);
        chk("m0_pulses", rises, 8);
        chk("m0_gap", last_gap, 1);
        ticks(4);
        chk("m0_cs_rise", cs_rise_cyc - acc_cyc, 18);
        chk("m0_idle_busy", bus.busy, 0);
        chk("m0_rxv_pulse", rx_cnt, 1);

        // Mode 3, H=4, two-byte frame with miso tied high.
        loop_en = 1'b0;
        miso_fix = 1'b1;
        set_cfg(1'b1, 1'b1, 8'd3);
        ticks(3);
        clr();
        send(8'h3C, 1'b0);
        wait_rx(2);
        chk("m3_lat1", rx_cyc - acc_cyc, 68);
        chk("m3_rx1", rx_byte, 8'hFF);
        chk("m3_mosi1", mosi_cap, 8'h3C);
        ticks(2);
        chk("m3_wait_cs", bus.cs, 0);
        chk("m3_wait_sclk", bus.sclk, 1);
        chk("m3_wait_ready", bus.tx_ready, 1);
        clr();
        send(8'hC3, 1'b1);
        wait_rx(3);
        chk("m3_lat2", rx_cyc - acc_cyc, 68);
        chk("m3_rx2", rx_byte, 8'hFF);
        chk("m3_mosi2", mosi_cap, 8'hC3);
        chk("m3_cs_low", cs_rises, 0);
        ticks(10);
        chk("m3_cs_rise", cs_rise_cyc - acc_cyc, 72);

        // Long WAIT with requests toggling while busy.
        loop_en = 1'b1;
        set_cfg(1'b0, 1'b0, 8'd1);
        ticks(3);
        clr();
        send(8'h5A, 1'b0);
        ready_seen = 0;
        bus.tx_data = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            bus.tx_valid = ~bus.tx_valid;
            if (bus.tx_ready) ready_seen++;
            ticks(1);
        end
        bus.tx_valid = 1'b0;
        chk("wt_no_ready", ready_seen, 0);
        wait_rx(4);
        chk("wt_lat", rx_cyc - acc_cyc, 34);
        chk("wt_rx", rx_byte, 8'h5A);
        ticks(2);
        clr();
        ticks(1000);
        chk("wt_edges", sclk_edges, 0);
        chk("wt_cs_rises", cs_rises, 0);
        chk("wt_cs", bus.cs, 0);
        chk("wt_busy", bus.busy, 1);
        chk("wt_rx_count", rx_cnt, 4);
        send(8'h0F, 1'b1);
        wait_rx(5);
        chk("wt_rx2", rx_byte, 8'h0F);
        chk("wt_mosi2", mosi_cap, 8'h0F);
        ticks(12);

        // Config change mid-byte must not disturb the byte in flight.
        set_cfg(1'b0, 1'b0, 8'd0);
        ticks(3);
        clr();
        send(8'h96, 1'b1);
        ticks(4);
        set_cfg(1'b1, 1'b0, 8'd7);
        wait_rx(6);
        chk("cc_lat", rx_cyc - acc_cyc, 17);
        chk("cc_rx", rx_byte, 8'h96);
        chk("cc_gap", last_gap, 1);
        chk("cc_pulses", rises, 8);
        chk("cc_sclk_end", bus.sclk, 0);
        ticks(6);
        chk("cc_idle_sclk", bus.sclk, 1);
        send(8'h42, 1'b1);
        wait_rx(7);
        chk("cc_lat2", rx_cyc - acc_cyc, 136);
        chk("cc_rx2", rx_byte, 8'h42);
        chk("cc_gap2", last_gap, 8);
        ticks(30);

        // Reset asserted at sclk edge 9 of a byte.
        set_cfg(1'b0, 1'b0, 8'd1);
        ticks(3);
        clr();
        send(8'hFF, 1'b1);
        for (int i = 0; i < 100 && sclk_edges < 9; i++) ticks(1);
        chk("rs_edge9", sclk_edges, 9);
        n_rx = rx_cnt;
        reset_n = 1'b0;
        #1;
        chk("rs_cs", bus.cs, 1);
        chk("rs_sclk", bus.sclk, 0);
        chk("rs_busy", bus.busy, 0);
        chk("rs_ready", bus.tx_ready, 1);
        chk("rs_rxd", bus.rx_data, 8'h00);
        ticks(3);
        reset_n = 1'b1;
        ticks(60);
        chk("rs_no_rxv", rx_cnt, n_rx);
        set_cfg(1'b0, 1'b0, 8'd0);
        ticks(3);
        clr();
        send(8'h81, 1'b1);
        wait_rx(n_rx + 1);
        chk("rs_lat", rx_cyc - acc_cyc, 17);
        chk("rs_rx", rx_byte, 8'h81);
        chk("rs_mosi", mosi_cap, 8'h81);
        ticks(6);

        // Slowest half-period.
        set_cfg(1'b0, 1'b0, 8'd255);
        ticks(3);
        clr();
        send(8'hC6, 1'b1);
        wait_rx(n_rx + 2);
        chk("hp_lat", rx_cyc - acc_cyc, 17 * 256);
        chk("hp_rx", rx_byte, 8'hC6);
        chk("hp_gap", last_gap, 256);
        ticks(600);
        chk("hp_idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
